// File: rtl/fir_tap_reader_pkg.sv
// fir_tap_reader_pkg: shared FIR delay-line sizes and tap-reader state encodings
package fir_tap_reader_pkg;
    localparam int FIR_ADDR_W = 14;
    localparam int FIR_TAPS   = 16;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/fir_tap_reader_tap_counter.sv
// fir_tap_reader_tap_counter: tap index counter with clear, increment and terminal count
module fir_tap_reader_tap_counter #(
    parameter int W    = 4,
    parameter int TAPS = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_enable,
    output logic [W-1:0] o_count,
    output logic         o_tc
);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_count <= '0;
        else if (i_load) o_count <= '0;
        else if (i_enable) o_count <= o_count + 1'b1;
    end
    assign o_tc = (o_count == W'(TAPS - 1));
endmodule

// File: rtl/fir_tap_reader.sv
// fir_tap_reader: walks the sample delay line backward and the coefficient ROM forward,
// one read per cycle for TAPS reads per START
module fir_tap_reader
    import fir_tap_reader_pkg::*;
#(
    parameter int ADDR_W = FIR_ADDR_W,
    parameter int TAPS   = FIR_TAPS,
    parameter int TAP_W  = $clog2(TAPS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_wr_ptr,
    input  logic              i_stall,
    output logic [ADDR_W-1:0] o_sample_addr,
    output logic [TAP_W-1:0]  o_coef_addr,
    output logic              o_rd_valid,
    output logic              o_first,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_done
);
    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_base, w_base_nxt;
    logic [TAP_W-1:0]  w_tap, w_tap_nxt;
    logic              w_tc, w_accept, w_consume, w_load, w_run;
    logic [ADDR_W-1:0] w_sample_nxt;
    logic [TAP_W-1:0]  w_coef_nxt;
    logic              w_first_nxt, w_last_nxt, w_done_nxt;

    assign w_accept   = i_start && (r_state != S_RUN);
    assign w_consume  = (r_state == S_RUN) && !i_stall;
    assign w_load     = w_accept || (w_consume && w_tc);
    assign w_tap_nxt  = w_load ? '0 : w_consume ? w_tap + 1'b1 : w_tap;
    assign w_base_nxt = w_accept ? i_wr_ptr : r_base;

    fir_tap_reader_tap_counter #(.W(TAP_W), .TAPS(TAPS)) u_tap (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (w_load),
        .i_enable (w_consume),
        .o_count  (w_tap),
        .o_tc     (w_tc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_base  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_base  <= w_base_nxt;
        end
    end

    // IDLE and DONE both fall to IDLE without a START
    always_comb begin
        w_state_nxt = (r_state == S_RUN) ? ((w_consume && w_tc) ? S_DONE : S_RUN)
                                         : (i_start ? S_RUN : S_IDLE);
    end

    // Outputs are computed from next-state values so they can be registered with no added latency
    always_comb begin
        w_run        = (w_state_nxt == S_RUN);
        w_sample_nxt = w_run ? w_base_nxt - ADDR_W'(w_tap_nxt) : '0;
        w_coef_nxt   = w_run ? w_tap_nxt : '0;
        w_first_nxt  = w_run && (w_tap_nxt == '0);
        w_last_nxt   = w_run && (w_tap_nxt == TAP_W'(TAPS - 1));
        w_done_nxt   = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sample_addr <= '0;
            o_coef_addr   <= '0;
            o_rd_valid    <= 1'b0;
            o_first       <= 1'b0;
            o_last        <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            o_sample_addr <= w_sample_nxt;
            o_coef_addr   <= w_coef_nxt;
            o_rd_valid    <= w_run;
            o_first       <= w_first_nxt;
            o_last        <= w_last_nxt;
            o_busy        <= w_run;
            o_done        <= w_done_nxt;
        end
    end
endmodule
